// File: rtl/lightboard_pkg.sv
// Shared canvas constants, coordinate types and rasterizer state encoding.
package lightboard_pkg;

   localparam int unsigned CANVAS_W = 1280;
   localparam int unsigned CANVAS_H = 720;

   typedef logic [10:0] x_t;
   typedef logic [9:0]  y_t;

   // Line arithmetic: dx, dy, err and e2 fit in 13 signed bits for the canvas size.
   typedef logic signed [12:0] sval_t;
   typedef logic [10:0]        rem_t;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStep,
      StEmit
   } ras_state_t;

   function automatic sval_t abs13(input sval_t v);
      return v[12] ? -v : v;
   endfunction

endpackage

// File: rtl/stroke_rasterizer_if.sv
// Point input stream and pixel output stream of the stroke rasterizer.
interface stroke_rasterizer_if;
   import lightboard_pkg::*;

   x_t   x_in;
   y_t   y_in;
   logic valid_in;
   logic pen_down_in;
   logic ready_out;
   x_t   pixel_x_out;
   y_t   pixel_y_out;
   logic pixel_valid_out;
   logic pixel_ready_in;
   logic busy_out;

   // Master drives points and accepts pixels.
   modport master (
      output x_in, y_in, valid_in, pen_down_in, pixel_ready_in,
      input  ready_out, pixel_x_out, pixel_y_out, pixel_valid_out, busy_out
   );

   // Slave is the rasterizer itself.
   modport slave (
      input  x_in, y_in, valid_in, pen_down_in, pixel_ready_in,
      output ready_out, pixel_x_out, pixel_y_out, pixel_valid_out, busy_out
   );

endinterface

// File: rtl/bresenham_step.sv
// One Bresenham iteration: advances the current point and error term.
module bresenham_step
   import lightboard_pkg::*;
(
   input  x_t    cur_x_i,
   input  y_t    cur_y_i,
   input  sval_t err_i,
   input  sval_t dx_i,
   input  sval_t dy_i,
   input  logic  sx_neg_i,
   input  logic  sy_neg_i,
   output x_t    next_x_o,
   output y_t    next_y_o,
   output sval_t next_err_o
);

   sval_t e2;
   sval_t err_acc;

   assign e2 = err_i <<< 1;

   // Both axis decisions use the same e2, so a diagonal move updates err twice.
   always_comb begin
      err_acc  = err_i;
      next_x_o = cur_x_i;
      next_y_o = cur_y_i;
      if (e2 >= dy_i) begin
         err_acc  = err_acc + dy_i;
         next_x_o = sx_neg_i ? cur_x_i - x_t'(1) : cur_x_i + x_t'(1);
      end
      if (e2 <= dx_i) begin
         err_acc  = err_acc + dx_i;
         next_y_o = sy_neg_i ? cur_y_i - y_t'(1) : cur_y_i + y_t'(1);
      end
      next_err_o = err_acc;
   end

endmodule

// File: rtl/stroke_rasterizer.sv
// Turns successive centroid points into a stream of pixels joining them.
module stroke_rasterizer
   import lightboard_pkg::*;
#(
   parameter int unsigned WIDTH  = CANVAS_W,
   parameter int unsigned HEIGHT = CANVAS_H
) (
   input logic                clk_in,
   input logic                rst_in,
   stroke_rasterizer_if.slave bus
);

   localparam x_t X_MAX = x_t'(WIDTH - 1);
   localparam y_t Y_MAX = y_t'(HEIGHT - 1);

   ras_state_t state_q;
   logic       has_prev_q;
   x_t         prev_x_q, new_x_q, cur_x_q;
   y_t         prev_y_q, new_y_q, cur_y_q;
   sval_t      err_q, dx_q, dy_q;
   logic       sx_neg_q, sy_neg_q;
   rem_t       remaining_q;
   logic       pixel_valid_q, ready_q, busy_q;

   x_t    x_clamp;
   y_t    y_clamp;
   sval_t x_diff, y_diff, abs_dx, abs_dy;
   rem_t  steps;
   x_t    step_x;
   y_t    step_y;
   sval_t step_err;

   // Clamp incoming points onto the canvas.
   always_comb begin
      x_clamp = (32'(bus.x_in) >= WIDTH)  ? X_MAX : bus.x_in;
      y_clamp = (32'(bus.y_in) >= HEIGHT) ? Y_MAX : bus.y_in;
   end

   // Line setup terms from prev to new; the step count is the major-axis length.
   always_comb begin
      x_diff = sval_t'({2'b00, new_x_q}) - sval_t'({2'b00, prev_x_q});
      y_diff = sval_t'({3'b000, new_y_q}) - sval_t'({3'b000, prev_y_q});
      abs_dx = abs13(x_diff);
      abs_dy = abs13(y_diff);
      steps  = (abs_dx >= abs_dy) ? rem_t'(abs_dx) : rem_t'(abs_dy);
   end

   bresenham_step u_step (
      .cur_x_i    (cur_x_q),
      .cur_y_i    (cur_y_q),
      .err_i      (err_q),
      .dx_i       (dx_q),
      .dy_i       (dy_q),
      .sx_neg_i   (sx_neg_q),
      .sy_neg_i   (sy_neg_q),
      .next_x_o   (step_x),
      .next_y_o   (step_y),
      .next_err_o (step_err)
   );

   // Rasterizer FSM with registered handshake outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= StIdle;
         has_prev_q    <= 1'b0;
         prev_x_q      <= '0;
         prev_y_q      <= '0;
         new_x_q       <= '0;
         new_y_q       <= '0;
         cur_x_q       <= '0;
         cur_y_q       <= '0;
         err_q         <= '0;
         dx_q          <= '0;
         dy_q          <= '0;
         sx_neg_q      <= 1'b0;
         sy_neg_q      <= 1'b0;
         remaining_q   <= '0;
         pixel_valid_q <= 1'b0;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.valid_in) begin
                  if (bus.pen_down_in) begin
                     new_x_q <= x_clamp;
                     new_y_q <= y_clamp;
                     state_q <= StSetup;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     // Pen lifted: the next stroke must not connect to this one.
                     has_prev_q <= 1'b0;
                  end
               end
            end
            StSetup: begin
               prev_x_q   <= new_x_q;
               prev_y_q   <= new_y_q;
               has_prev_q <= 1'b1;
               if (!has_prev_q) begin
                  cur_x_q       <= new_x_q;
                  cur_y_q       <= new_y_q;
                  remaining_q   <= '0;
                  pixel_valid_q <= 1'b1;
                  state_q       <= StEmit;
               end else if (new_x_q == prev_x_q && new_y_q == prev_y_q) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  // Start point is skipped; the previous line already drew it.
                  cur_x_q     <= prev_x_q;
                  cur_y_q     <= prev_y_q;
                  dx_q        <= abs_dx;
                  dy_q        <= -abs_dy;
                  sx_neg_q    <= x_diff[12];
                  sy_neg_q    <= y_diff[12];
                  err_q       <= abs_dx - abs_dy;
                  remaining_q <= steps;
                  state_q     <= StStep;
               end
            end
            StStep: begin
               cur_x_q       <= step_x;
               cur_y_q       <= step_y;
               err_q         <= step_err;
               remaining_q   <= remaining_q - rem_t'(1);
               pixel_valid_q <= 1'b1;
               state_q       <= StEmit;
            end
            StEmit: begin
               if (bus.pixel_ready_in) begin
                  pixel_valid_q <= 1'b0;
                  if (remaining_q == '0) begin
                     state_q <= StIdle;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StStep;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ready_out       = ready_q;
   assign bus.busy_out        = busy_q;
   assign bus.pixel_valid_out = pixel_valid_q;
   assign bus.pixel_x_out     = cur_x_q;
   assign bus.pixel_y_out     = cur_y_q;

endmodule

// File: tb/tb_stroke_rasterizer.sv
// Self-checking bench: directed scenarios plus random points against a line model.
module tb_stroke_rasterizer;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;

   stroke_rasterizer_if bus ();

   stroke_rasterizer dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit m_has_prev = 1'b0;
   int m_px = 0, m_py = 0;
   int exp_x[$], exp_y[$];
   int got_x[$], got_y[$], got_t[$];
   int last_exit;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected pixels for one accepted point, straight from the drawing rules.
   task automatic model(input int x, input int y, input bit pen);
      int cx, cy, x0, y0, dx, dy, sx, sy, err, e2, guard;
      exp_x.delete();
      exp_y.delete();
      cx = (x > 1279) ? 1279 : x;
      cy = (y > 719) ? 719 : y;
      if (!pen) begin
         m_has_prev = 1'b0;
         return;
      end
      if (!m_has_prev) begin
         exp_x.push_back(cx);
         exp_y.push_back(cy);
      end else if (!(cx == m_px && cy == m_py)) begin
         x0 = m_px; y0 = m_py;
         dx = (cx > x0) ? cx - x0 : x0 - cx;
         dy = (cy > y0) ? y0 - cy : cy - y0;
         sx = (x0 < cx) ? 1 : -1;
         sy = (y0 < cy) ? 1 : -1;
         err = dx + dy;
         guard = 0;
         while (!(x0 == cx && y0 == cy) && guard < 5000) begin
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x0 += sx; end
            if (e2 <= dx) begin err += dx; y0 += sy; end
            exp_x.push_back(x0);
            exp_y.push_back(y0);
            guard++;
         end
      end
      m_px = cx;
      m_py = cy;
      m_has_prev = 1'b1;
   endtask

   // Present one point, collect every handshaked pixel and compare with the model.
   task automatic run_point(input int x, input int y, input bit pen, input int bp_pct,
                            input int stall_first, input int drop_at, input string tag);
      int  c, stall, px, py;
      bit  pending;
      logic [31:0] xv, yv;
      model(x, y, pen);
      got_x.delete(); got_y.delete(); got_t.delete();
      xv = x; yv = y;
      bus.x_in = xv[10:0];
      bus.y_in = yv[9:0];
      bus.pen_down_in = pen;
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      c = 1;
      pending = 1'b0;
      stall = stall_first;
      px = 0; py = 0;
      while (bus.ready_out !== 1'b1 && c < 10000) begin
         if (pending) begin
            check({tag, " hold-valid"}, 32'(bus.pixel_valid_out), 1);
            check({tag, " hold-x"}, 32'(bus.pixel_x_out), px);
            check({tag, " hold-y"}, 32'(bus.pixel_y_out), py);
         end
         if (bus.pixel_valid_out === 1'b1) begin
            if (stall > 0) begin
               bus.pixel_ready_in = 1'b0;
               stall--;
            end else begin
               bus.pixel_ready_in = ($urandom_range(99) >= bp_pct);
            end
            if (bus.pixel_ready_in) begin
               got_x.push_back(int'(bus.pixel_x_out));
               got_y.push_back(int'(bus.pixel_y_out));
               got_t.push_back(c);
               pending = 1'b0;
            end else begin
               pending = 1'b1;
               px = int'(bus.pixel_x_out);
               py = int'(bus.pixel_y_out);
            end
         end else begin
            bus.pixel_ready_in = 1'($urandom_range(1));
            pending = 1'b0;
         end
         if (c == drop_at) begin
            bus.x_in = 11'd5;
            bus.y_in = 10'd5;
            bus.pen_down_in = 1'b1;
            bus.valid_in = 1'b1;
         end else begin
            bus.valid_in = 1'b0;
         end
         tick();
         c++;
      end
      bus.valid_in = 1'b0;
      bus.pixel_ready_in = 1'b1;
      last_exit = c;
      check({tag, " finished"}, 32'(c < 10000), 1);
      check({tag, " count"}, got_x.size(), exp_x.size());
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
         if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
            check($sformatf("%s px%0d x", tag, i), got_x[i], exp_x[i]);
            check($sformatf("%s px%0d y", tag, i), got_y[i], exp_y[i]);
            break;
         end
      end
   endtask

   initial begin
      int rx, ry;
      bit rp;
      bus.x_in = '0;
      bus.y_in = '0;
      bus.valid_in = 1'b0;
      bus.pen_down_in = 1'b0;
      bus.pixel_ready_in = 1'b1;

      // Reset held three cycles
      rst_in = 1'b1;
      repeat (3) tick();
      rst_in = 1'b0;
      check("rst valid", 32'(bus.pixel_valid_out), 0);
      check("rst x", 32'(bus.pixel_x_out), 0);
      check("rst y", 32'(bus.pixel_y_out), 0);
      check("rst busy", 32'(bus.busy_out), 0);
      check("rst ready", 32'(bus.ready_out), 1);

      // First point: single pixel at cycle 2
      run_point(100, 50, 1'b1, 0, 0, 0, "first");
      check("first t", (got_t.size() > 0) ? got_t[0] : -1, 2);
      check("first ready cyc3", last_exit, 3);
      tick();
      check("first ready cyc4", 32'(bus.ready_out), 1);
      check("first busy cyc4", 32'(bus.busy_out), 0);

      // Diagonal line, ready held high
      run_point(104, 52, 1'b1, 0, 0, 0, "diag");
      check("diag n", got_x.size(), 4);
      if (got_x.size() == 4) begin
         check("diag p0", got_x[0] * 1000 + got_y[0], 101051);
         check("diag p1", got_x[1] * 1000 + got_y[1], 102051);
         check("diag p2", got_x[2] * 1000 + got_y[2], 103052);
         check("diag p3", got_x[3] * 1000 + got_y[3], 104052);
         check("diag t0", got_t[0], 3);
         for (int i = 1; i < 4; i++)
            check($sformatf("diag gap%0d", i), got_t[i] - got_t[i-1], 2);
      end

      // Negative direction with first pixel stalled five cycles
      run_point(10, 10, 1'b1, 0, 0, 0, "to10");
      run_point(10, 7, 1'b1, 0, 5, 0, "bp");
      check("bp n", got_x.size(), 3);
      if (got_x.size() == 3) begin
         check("bp p0", got_x[0] * 1000 + got_y[0], 10009);
         check("bp p1", got_x[1] * 1000 + got_y[1], 10008);
         check("bp p2", got_x[2] * 1000 + got_y[2], 10007);
      end

      // Pen up, fresh stroke, repeated point
      run_point(50, 60, 1'b0, 0, 0, 0, "penup");
      check("penup n", got_x.size(), 0);
      run_point(300, 200, 1'b1, 0, 0, 0, "fresh");
      check("fresh n", got_x.size(), 1);
      if (got_x.size() == 1) check("fresh p", got_x[0] * 1000 + got_y[0], 300200);
      run_point(300, 200, 1'b1, 0, 0, 0, "repeat");
      check("repeat n", got_x.size(), 0);

      // Clamping after a pen lift
      run_point(0, 0, 1'b0, 0, 0, 0, "lift");
      run_point(2000, 900, 1'b1, 0, 0, 0, "clamp");
      check("clamp n", got_x.size(), 1);
      if (got_x.size() == 1) check("clamp p", got_x[0] * 10000 + got_y[0], 12790719);

      // Point pulsed while busy is dropped; prev must stay intact
      run_point(1270, 712, 1'b1, 20, 0, 4, "drop");
      run_point(1262, 715, 1'b1, 0, 0, 0, "after-drop");

      // Reset in the middle of a line
      bus.x_in = 11'd600;
      bus.y_in = 10'd400;
      bus.pen_down_in = 1'b1;
      bus.valid_in = 1'b1;
      bus.pixel_ready_in = 1'b0;
      tick();
      bus.valid_in = 1'b0;
      for (int i = 0; i < 20 && bus.pixel_valid_out !== 1'b1; i++) tick();
      check("midline valid before", 32'(bus.pixel_valid_out), 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      bus.pixel_ready_in = 1'b1;
      check("midrst valid", 32'(bus.pixel_valid_out), 0);
      check("midrst ready", 32'(bus.ready_out), 1);
      check("midrst busy", 32'(bus.busy_out), 0);
      m_has_prev = 1'b0;
      run_point(7, 8, 1'b1, 0, 0, 0, "post-rst");
      check("post-rst n", got_x.size(), 1);

      // Random strokes with backpressure and stray points
      for (int k = 0; k < 40; k++) begin
         rp = ($urandom_range(5) != 0);
         rx = ($urandom_range(9) == 0) ? int'($urandom_range(1200, 2047)) : int'($urandom_range(150));
         ry = ($urandom_range(9) == 0) ? int'($urandom_range(650, 1023)) : int'($urandom_range(120));
         run_point(rx, ry, rp, 30, 0, int'($urandom_range(1, 25)), $sformatf("rnd%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
